// File: rtl/uart_cfg_pkg.sv
// Shared types and constants for the UART configuration sequencer.
// Register addresses follow the 16550 map; DLL/DLM alias RBR/IER while DLAB is set.
package uart_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2,
    ERR  = 2'd3
  } state_e;

  localparam logic [4:0] REG_RBR_DLL = 5'd0;
  localparam logic [4:0] REG_IER_DLM = 5'd1;
  localparam logic [4:0] REG_FCR     = 5'd2;
  localparam logic [4:0] REG_LCR     = 5'd3;

  localparam int NUM_STEPS = 6;

  typedef struct packed {
    logic [4:0] adr;
    logic [7:0] dat;
  } wr_t;

  // Address/data of one step of the programming sequence.
  function automatic wr_t step_write(input logic [2:0]  step,
                                     input logic [15:0] div,
                                     input logic [7:0]  lcr,
                                     input logic [7:0]  fcr,
                                     input logic [7:0]  ier);
    wr_t w;
    w.adr = REG_RBR_DLL;
    w.dat = 8'h00;
    case (step)
      3'd0: begin w.adr = REG_LCR;     w.dat = lcr | 8'h80; end
      3'd1: begin w.adr = REG_RBR_DLL; w.dat = div[7:0];    end
      3'd2: begin w.adr = REG_IER_DLM; w.dat = div[15:8];   end
      3'd3: begin w.adr = REG_LCR;     w.dat = lcr & 8'h7F; end
      3'd4: begin w.adr = REG_FCR;     w.dat = fcr;         end
      3'd5: begin w.adr = REG_IER_DLM; w.dat = ier;         end
      default: begin w.adr = REG_RBR_DLL; w.dat = 8'h00;    end
    endcase
    return w;
  endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Per-write acknowledge timeout: counts cycles without ack since the last clear.
// expired_o fires in the cycle whose count step would reach TIMEOUT.
module wb_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CW'(TIMEOUT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign expired_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_cfg_seq.sv
// Programs a 16550-style UART over Wishbone classic with a fixed 6-write sequence.
//
// state | meaning
// IDLE  | waiting for start (or auto-start after reset)
// REQ   | write strobes asserted, waiting for ack or timeout
// GAP   | one idle bus cycle between writes
// ERR   | last write timed out; strobes low, waiting for a retry start
module uart_cfg_seq
  import uart_cfg_pkg::*;
#(
  parameter logic [15:0] DIV_DEFAULT = 16'd27,
  parameter logic [7:0]  LCR_VAL     = 8'h03,
  parameter logic [7:0]  FCR_VAL     = 8'hC6,
  parameter logic [7:0]  IER_VAL     = 8'h01,
  parameter int          TIMEOUT     = 255,
  parameter int          AUTO_START  = 1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start_i,
  input  logic [15:0] divisor_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [4:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  input  logic        wb_ack_i
);

  state_e      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [15:0] div_q, div_d;
  logic        first_q, first_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic        cyc_q, cyc_d;
  logic [4:0]  adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;

  logic        start_eff;
  logic [15:0] div_in;
  logic        idle_like;
  wr_t         wr;
  logic        tmo_clr, tmo_en, tmo_exp;

  // The first edge out of reset behaves as a start with the default divisor.
  assign start_eff = start_i | first_q;
  assign div_in    = first_q ? DIV_DEFAULT : divisor_i;
  assign idle_like = (state_q == IDLE) || (state_q == ERR);

  always_comb begin
    wr = idle_like ? step_write(3'd0, div_in, LCR_VAL, FCR_VAL, IER_VAL)
                   : step_write(3'(step_q + 3'd1), div_q, LCR_VAL, FCR_VAL, IER_VAL);
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    div_d   = div_q;
    first_d = 1'b0;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    cyc_d   = cyc_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    tmo_clr = 1'b0;
    tmo_en  = 1'b0;
    case (state_q)
      IDLE, ERR: begin
        if (start_eff) begin
          done_d = 1'b0;
          if (div_in != 16'd0) begin
            div_d   = div_in;
            step_d  = 3'd0;
            err_d   = 1'b0;
            state_d = REQ;
            busy_d  = 1'b1;
            cyc_d   = 1'b1;
            adr_d   = wr.adr;
            dat_d   = {4{wr.dat}};
            sel_d   = 4'b0001 << wr.adr[1:0];
            tmo_clr = 1'b1;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      REQ: begin
        tmo_en = !wb_ack_i;
        if (wb_ack_i) begin
          cyc_d   = 1'b0;
          state_d = GAP;
        end else if (tmo_exp) begin
          cyc_d   = 1'b0;
          busy_d  = 1'b0;
          err_d   = 1'b1;
          state_d = ERR;
        end
      end
      GAP: begin
        if (step_q == 3'(NUM_STEPS - 1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          step_d  = 3'(step_q + 3'd1);
          cyc_d   = 1'b1;
          adr_d   = wr.adr;
          dat_d   = {4{wr.dat}};
          sel_d   = 4'b0001 << wr.adr[1:0];
          tmo_clr = 1'b1;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_q <= IDLE;
      step_q  <= 3'd0;
      div_q   <= 16'd0;
      first_q <= (AUTO_START != 0);
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cyc_q   <= 1'b0;
      adr_q   <= 5'd0;
      dat_q   <= 32'd0;
      sel_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      div_q   <= div_d;
      first_q <= first_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
    end
  end

  wb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk_i     (wb_clk_i),
    .rst_ni    (wb_rst_i),
    .clr_i     (tmo_clr),
    .en_i      (tmo_en),
    .expired_o (tmo_exp)
  );

  // Classic write-only master: cyc, stb and we always move together.
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign err_o    = err_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = cyc_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_sel_o = sel_q;

endmodule

// File: tb/tb_uart_cfg_seq.sv
// Scoreboard bench for uart_cfg_seq: a reference model queues expected writes,
// a monitor pops and compares on every acknowledged bus write.
module tb_uart_cfg_seq;

  localparam logic [7:0] LCR = 8'h03;
  localparam logic [7:0] FCR = 8'hC6;
  localparam logic [7:0] IER = 8'h01;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] div = 16'd0;
  logic        busy, done, err, cyc, stb, we, ack;
  logic [4:0]  adr;
  logic [31:0] dat;
  logic [3:0]  sel;

  always #5 clk = ~clk;

  uart_cfg_seq dut (
    .wb_clk_i (clk),  .wb_rst_i (rst_n), .start_i (start), .divisor_i (div),
    .busy_o   (busy), .done_o   (done),  .err_o   (err),
    .wb_adr_o (adr),  .wb_dat_o (dat),   .wb_sel_o (sel),
    .wb_cyc_o (cyc),  .wb_stb_o (stb),   .wb_we_o (we),
    .wb_ack_i (ack)
  );

  typedef struct {
    logic [4:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Reference model: the six register writes of one configuration sequence.
  task automatic push_seq(input logic [15:0] d);
    int   a[6];
    logic [7:0] b[6];
    exp_t e;
    a = '{3, 0, 1, 3, 2, 1};
    b[0] = LCR | 8'h80;
    b[1] = d[7:0];
    b[2] = d[15:8];
    b[3] = LCR & 8'h7F;
    b[4] = FCR;
    b[5] = IER;
    for (int i = 0; i < 6; i++) begin
      e.adr = 5'(a[i]);
      e.dat = {4{b[i]}};
      e.sel = 4'(1 << (a[i] % 4));
      exp_q.push_back(e);
    end
  endtask

  // Slave: acks after ack_delay wait cycles; can refuse one chosen write.
  int   wait_cnt = 0;
  int   ack_cnt = 0;
  int   ack_delay = 0;
  int   noack_abs = -1;
  logic spur = 1'b0;

  assign ack = (cyc && stb && (wait_cnt == ack_delay) && (ack_cnt != noack_abs)) || (spur && !cyc);

  always @(posedge clk) begin
    if (!rst_n || !(cyc && stb) || ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
    if (rst_n && cyc && stb && ack) ack_cnt <= ack_cnt + 1;
  end

  initial begin : monitor
    logic prev;
    logic unstable;
    exp_t first_w;
    exp_t e;
    prev = 1'b0;
    unstable = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || !(cyc && stb)) begin
        prev = 1'b0;
      end else begin
        if (!prev) begin
          first_w.adr = adr; first_w.dat = dat; first_w.sel = sel;
          unstable = 1'b0;
        end else if (adr !== first_w.adr || dat !== first_w.dat || sel !== first_w.sel) begin
          unstable = 1'b1;
        end
        prev = 1'b1;
        if (ack) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write: got adr=%0h dat=%0h, required no write", adr, dat);
          end else begin
            e = exp_q.pop_front();
            chk("wr_adr", 32'(adr), 32'(e.adr));
            chk("wr_dat", dat, e.dat);
            chk("wr_sel", 32'(sel), 32'(e.sel));
            chk("wr_we", 32'(we), 32'd1);
            chk("wr_stable", 32'(unstable), 32'd0);
          end
        end
      end
    end
  end

  task automatic pulse_start(input logic [15:0] d);
    @(negedge clk);
    start = 1'b1;
    div = d;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts busy and strobe cycles until idle; optional stray starts and acks.
  task automatic wait_idle(input string name, input int budget, input logic noisy,
                           output int busy_cyc, output int stb_cyc);
    int n;
    busy_cyc = 0;
    stb_cyc = 0;
    for (n = 0; n < budget; n++) begin
      if (!busy) break;
      busy_cyc++;
      if (cyc && stb) stb_cyc++;
      @(negedge clk);
      if (noisy) begin
        start = busy && ($urandom_range(0, 5) == 0);
        div = 16'($urandom);
        spur = $urandom_range(0, 3) == 0;
      end
    end
    start = 1'b0;
    spur = 1'b0;
    if (n >= budget) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got busy after %0d cycles, required idle", name, budget);
    end
  endtask

  task automatic chk_idle_done(input string name);
    chk({name, "_done"}, 32'(done), 32'd1);
    chk({name, "_err"}, 32'(err), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_done"}, 32'(done), 32'd0);
    chk({name, "_err"}, 32'(err), 32'd0);
    chk({name, "_cyc"}, 32'(cyc), 32'd0);
    chk({name, "_stb"}, 32'(stb), 32'd0);
    chk({name, "_we"}, 32'(we), 32'd0);
    chk({name, "_adr"}, 32'(adr), 32'd0);
    chk({name, "_dat"}, dat, 32'd0);
    chk({name, "_sel"}, 32'(sel), 32'd0);
  endtask

  initial begin : main
    int bc, sc, base;
    logic [15:0] d;

    // Reset, then auto-start with the default divisor and a zero-wait slave.
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    push_seq(16'd27);
    rst_n = 1'b1;
    @(negedge clk);
    chk("autostart_busy", 32'(busy), 32'd1);
    wait_idle("autostart", 2000, 1'b0, bc, sc);
    chk("autostart_cycles", bc, 12);
    chk_idle_done("autostart");

    ack_delay = 1;
    push_seq(16'h0145);
    pulse_start(16'h0145);
    wait_idle("div0145", 2000, 1'b0, bc, sc);
    chk("div0145_cycles", bc, 18);
    chk_idle_done("div0145");

    // Three wait cycles: four strobe cycles plus one gap per write.
    ack_delay = 3;
    push_seq(16'h5A3C);
    pulse_start(16'h5A3C);
    wait_idle("slow", 2000, 1'b0, bc, sc);
    chk("slow_busy_cycles", bc, 30);
    chk("slow_stb_cycles", sc, 24);
    chk_idle_done("slow");

    // Third write never acknowledged.
    ack_delay = 0;
    noack_abs = ack_cnt + 2;
    push_seq(16'd27);
    repeat (4) void'(exp_q.pop_back());
    pulse_start(16'd27);
    wait_idle("noack", 2000, 1'b0, bc, sc);
    chk("noack_stb_cycles", sc, 257);
    chk("noack_busy_cycles", bc, 259);
    chk("noack_err", 32'(err), 32'd1);
    chk("noack_done", 32'(done), 32'd0);
    chk("noack_cyc", 32'(cyc), 32'd0);
    chk("noack_drained", 32'(exp_q.size()), 32'd0);
    noack_abs = -1;

    // Zero divisor from the error state, then a valid retry.
    pulse_start(16'd0);
    chk("zdiv_cyc", 32'(cyc), 32'd0);
    chk("zdiv_busy", 32'(busy), 32'd0);
    chk("zdiv_err", 32'(err), 32'd1);
    chk("zdiv_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    chk("zdiv_cyc_later", 32'(cyc), 32'd0);
    push_seq(16'd27);
    pulse_start(16'd27);
    wait_idle("retry", 2000, 1'b0, bc, sc);
    chk_idle_done("retry");

    // Reset in the middle of the fourth write, then auto-restart.
    ack_delay = 2;
    base = ack_cnt;
    push_seq(16'h1234);
    pulse_start(16'h1234);
    for (int n = 0; n < 200; n++) begin
      if (ack_cnt == base + 3 && cyc && stb) break;
      @(negedge clk);
    end
    chk("midrst_reached_write4", 32'(cyc && stb && ack_cnt == base + 3), 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk_reset_outputs("midrst");
    push_seq(16'd27);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_busy", 32'(busy), 32'd1);
    wait_idle("restart", 2000, 1'b0, bc, sc);
    chk("restart_cycles", bc, 24);
    chk_idle_done("restart");

    // Random divisors and wait states, with stray starts and acks while busy.
    for (int it = 0; it < 12; it++) begin
      ack_delay = $urandom_range(0, 3);
      d = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
      if (d == 16'd0) begin
        pulse_start(d);
        chk("rnd_zdiv_err", 32'(err), 32'd1);
        chk("rnd_zdiv_done", 32'(done), 32'd0);
        chk("rnd_zdiv_cyc", 32'(cyc), 32'd0);
      end else begin
        push_seq(d);
        pulse_start(d);
        wait_idle("rnd", 2000, 1'b1, bc, sc);
        chk("rnd_cycles", bc, 6 * (ack_delay + 2));
        chk_idle_done("rnd");
      end
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
